// File: rtl/wave_gen.sv
`default_nettype none
// ============================================================================
// Module   : wave_gen
// Purpose  : Audio sine-sample generator. Each rising edge of aud_req yields
//            one signed 16-bit sample amp*sin(phi). The phase then advances by
//            a per-sample step. Step and amplitude arrive as IEEE-754 singles.
//            The sine is computed with a 16-iteration rotation-mode CORDIC.
// Ports    : clk       in   1  system clock, rising edge
//            reset     in   1  synchronous, active-high reset
//            aud_req   in   1  sample request (rising edge starts a sample)
//            aud_step  in  32  float, phase increment in radians per sample
//            aud_amp   in  32  float, peak amplitude in output LSBs
//            aud_data  out 16  signed two's-complement sample
//            aud_done  out  1  high while aud_data holds the latest result
// Revision : 1.0  initial release
// ============================================================================
module wave_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic        aud_req,
  input  logic [31:0] aud_step,
  input  logic [31:0] aud_amp,
  output logic [15:0] aud_data,
  output logic        aud_done
);

  // --------------------------------------------------------------------------
  // Constants. Angles are unsigned/signed Q3.29 radians.
  // --------------------------------------------------------------------------
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DECODE   = 3'd1;
  localparam logic [2:0] S_PRESCALE = 3'd2;
  localparam logic [2:0] S_ROTATE   = 3'd3;
  localparam logic [2:0] S_OUTPUT   = 3'd4;

  localparam logic [31:0] TWO_PI        = 32'hC90FDAA2;
  localparam logic [31:0] STEP_MAX      = 32'hC90FDAA1;  // TWO_PI - 1
  localparam logic [31:0] HALF_PI       = 32'h3243F6A9;
  localparam logic [31:0] PI            = 32'h6487ED51;
  localparam logic [31:0] THREE_HALF_PI = 32'h96CBE3FA;

  // 1/CORDIC gain in Q0.16, pre-applied to the amplitude so that the final
  // y is directly amp*sin(theta).
  localparam logic [15:0] CORDIC_K = 16'h9B75;
  localparam logic [14:0] AMP_MAX  = 15'd32767;

  // --------------------------------------------------------------------------
  // Float step -> Q3.29. The hidden-1 mantissa M (24 bits) represents
  // M * 2^(e-150); in Q3.29 that is M * 2^(e-121). Exponents of 130 and above
  // are at least 8.0, so they clamp without shifting.
  // --------------------------------------------------------------------------
  function automatic logic [31:0] decode_step(input logic [31:0] f);
    logic [7:0]  e;
    logic [31:0] m;
    logic [31:0] v;
    e = f[30:23];
    m = {8'd0, 1'b1, f[22:0]};
    v = 32'd0;
    if (e == 8'd0) begin
      v = 32'd0;                       // zero or denormal
    end else if (f[31]) begin
      v = 32'd0;                       // negative steps are not supported
    end else if (e >= 8'd130) begin
      v = STEP_MAX;                    // >= 8.0, Inf, NaN
    end else if (e >= 8'd121) begin
      v = m << (e - 8'd121);           // at most 8 places, fits in 32 bits
      if (v >= TWO_PI) begin
        v = STEP_MAX;
      end
    end else begin
      v = m >> (8'd121 - e);           // shifts of 32+ truncate to zero
    end
    return v;
  endfunction

  // --------------------------------------------------------------------------
  // Float amplitude magnitude -> unsigned integer, fraction truncated.
  // Exponents 127..141 cover [1, 32768); everything above saturates.
  // --------------------------------------------------------------------------
  function automatic logic [14:0] decode_amp(input logic [31:0] f);
    logic [7:0]  e;
    logic [23:0] m;
    logic [23:0] v;
    logic [14:0] r;
    e = f[30:23];
    m = {1'b1, f[22:0]};
    v = 24'd0;
    r = 15'd0;
    if (e < 8'd127) begin
      r = 15'd0;                       // zero, denormal or below 1.0
    end else if (e >= 8'd142) begin
      r = AMP_MAX;                     // >= 32768, Inf, NaN
    end else begin
      v = m >> (8'd150 - e);
      r = (v > 24'd32767) ? AMP_MAX : v[14:0];
    end
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Fold phi in [0, 2pi) into theta in [-pi/2, pi/2] with equal sine.
  // --------------------------------------------------------------------------
  function automatic logic signed [31:0] fold_phase(input logic [31:0] ph);
    logic [31:0] t;
    if (ph <= HALF_PI) begin
      t = ph;
    end else if (ph <= THREE_HALF_PI) begin
      t = PI - ph;
    end else begin
      t = ph - TWO_PI;                 // wraps to a negative two's-complement
    end
    return $signed(t);
  endfunction

  // --------------------------------------------------------------------------
  // atan(2^-i) in Q3.29, rounded to nearest.
  // --------------------------------------------------------------------------
  function automatic logic signed [31:0] atan_lut(input logic [3:0] i);
    logic signed [31:0] a;
    a = 32'sd0;
    case (i)
      4'd0:  a = 32'sd421657428;
      4'd1:  a = 32'sd248918915;
      4'd2:  a = 32'sd131521918;
      4'd3:  a = 32'sd66762579;
      4'd4:  a = 32'sd33510843;
      4'd5:  a = 32'sd16771755;
      4'd6:  a = 32'sd8387925;
      4'd7:  a = 32'sd4194219;
      4'd8:  a = 32'sd2097141;
      4'd9:  a = 32'sd1048575;
      4'd10: a = 32'sd524288;
      4'd11: a = 32'sd262144;
      4'd12: a = 32'sd131072;
      4'd13: a = 32'sd65536;
      4'd14: a = 32'sd32768;
      4'd15: a = 32'sd16384;
      default: a = 32'sd0;
    endcase
    return a;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]         state_q, state_d;
  logic               req_q, req_d;
  logic [31:0]        step_in_q, step_in_d;   // raw float words, latched
  logic [31:0]        amp_in_q, amp_in_d;     //   on the accepted edge
  logic [31:0]        step_q, step_d;         // decoded step, Q3.29
  logic [14:0]        amp_mag_q, amp_mag_d;
  logic               amp_neg_q, amp_neg_d;
  logic signed [19:0] x_q, x_d;               // integer LSBs with 3 guard bits
  logic signed [19:0] y_q, y_d;
  logic signed [31:0] z_q, z_d;               // residual angle, Q3.29
  logic [3:0]         iter_q, iter_d;
  logic [31:0]        phase_q, phase_d;
  logic [15:0]        data_q, data_d;
  logic               done_q, done_d;

  // FSM-decoded controls
  logic accept;
  logic do_decode;
  logic do_prescale;
  logic do_rotate;
  logic do_output;

  logic req_rise;
  assign req_rise = aud_req & ~req_q;

  // --------------------------------------------------------------------------
  // Combinational datapath helpers
  // --------------------------------------------------------------------------
  logic [30:0]        w_amp_prod;
  logic [14:0]        w_x_init;
  logic signed [19:0] w_x_shift;
  logic signed [19:0] w_y_shift;
  logic signed [31:0] w_atan;
  logic [19:0]        w_y_abs;
  logic [17:0]        w_y_rnd;
  logic [14:0]        w_y_sat;
  logic               w_out_neg;
  logic [15:0]        w_sample;
  logic [32:0]        w_phase_sum;
  logic [31:0]        w_phase_next;

  always_comb begin
    // x0 = round(amp * K); the product stays below 2^31 for amp <= 32767
    w_amp_prod = 31'(amp_mag_q) * 31'(CORDIC_K);
    w_x_init   = 15'((w_amp_prod + 31'h0000_8000) >> 16);

    w_x_shift = x_q >>> iter_q;
    w_y_shift = y_q >>> iter_q;
    w_atan    = atan_lut(iter_q);

    // Round half away from zero by rounding the magnitude, then saturate.
    // |y| stays well below 2^19, so the negation cannot overflow.
    w_y_abs   = y_q[19] ? 20'(-y_q) : 20'(y_q);
    w_y_rnd   = 18'(({1'b0, w_y_abs} + 21'd4) >> 3);
    w_y_sat   = (w_y_rnd > 18'd32767) ? AMP_MAX : w_y_rnd[14:0];
    w_out_neg = y_q[19] ^ amp_neg_q;
    w_sample  = w_out_neg ? (16'd0 - {1'b0, w_y_sat}) : {1'b0, w_y_sat};

    // phi < TWO_PI and step <= TWO_PI-1, so one subtraction always suffices
    w_phase_sum = {1'b0, phase_q} + {1'b0, step_q};
    if (w_phase_sum >= {1'b0, TWO_PI}) begin
      w_phase_next = w_phase_sum[31:0] - TWO_PI;
    end else begin
      w_phase_next = w_phase_sum[31:0];
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (req_rise) state_d = S_DECODE;
      S_DECODE:   state_d = S_PRESCALE;
      S_PRESCALE: state_d = S_ROTATE;
      S_ROTATE:   if (iter_q == 4'd15) state_d = S_OUTPUT;
      S_OUTPUT:   state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (datapath controls)
  // --------------------------------------------------------------------------
  always_comb begin
    accept      = 1'b0;
    do_decode   = 1'b0;
    do_prescale = 1'b0;
    do_rotate   = 1'b0;
    do_output   = 1'b0;
    case (state_q)
      S_IDLE:     accept      = req_rise;
      S_DECODE:   do_decode   = 1'b1;
      S_PRESCALE: do_prescale = 1'b1;
      S_ROTATE:   do_rotate   = 1'b1;
      S_OUTPUT:   do_output   = 1'b1;
      default:    accept      = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath next-state
  // --------------------------------------------------------------------------
  always_comb begin
    req_d     = aud_req;
    step_in_d = step_in_q;
    amp_in_d  = amp_in_q;
    step_d    = step_q;
    amp_mag_d = amp_mag_q;
    amp_neg_d = amp_neg_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    iter_d    = iter_q;
    phase_d   = phase_q;
    data_d    = data_q;
    done_d    = done_q;

    if (accept) begin
      step_in_d = aud_step;
      amp_in_d  = aud_amp;
      done_d    = 1'b0;
    end

    if (do_decode) begin
      step_d    = decode_step(step_in_q);
      amp_mag_d = decode_amp(amp_in_q);
      amp_neg_d = amp_in_q[31];
      z_d       = fold_phase(phase_q);
    end

    if (do_prescale) begin
      x_d    = {2'b00, w_x_init, 3'b000};
      y_d    = 20'sd0;
      iter_d = 4'd0;
    end

    if (do_rotate) begin
      // Rotate toward z = 0: positive residual means rotate counter-clockwise
      if (!z_q[31]) begin
        x_d = x_q - w_y_shift;
        y_d = y_q + w_x_shift;
        z_d = z_q - w_atan;
      end else begin
        x_d = x_q + w_y_shift;
        y_d = y_q - w_x_shift;
        z_d = z_q + w_atan;
      end
      iter_d = iter_q + 4'd1;
    end

    if (do_output) begin
      data_d  = w_sample;
      done_d  = 1'b1;
      phase_d = w_phase_next;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q     <= 1'b0;
      step_in_q <= 32'd0;
      amp_in_q  <= 32'd0;
      step_q    <= 32'd0;
      amp_mag_q <= 15'd0;
      amp_neg_q <= 1'b0;
      x_q       <= 20'sd0;
      y_q       <= 20'sd0;
      z_q       <= 32'sd0;
      iter_q    <= 4'd0;
      phase_q   <= 32'd0;
      data_q    <= 16'd0;
      done_q    <= 1'b0;
    end else begin
      req_q     <= req_d;
      step_in_q <= step_in_d;
      amp_in_q  <= amp_in_d;
      step_q    <= step_d;
      amp_mag_q <= amp_mag_d;
      amp_neg_q <= amp_neg_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      iter_q    <= iter_d;
      phase_q   <= phase_d;
      data_q    <= data_d;
      done_q    <= done_d;
    end
  end

  assign aud_data = data_q;
  assign aud_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_wave_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_wave_gen
// Purpose  : Directed self-checking bench for wave_gen. Expected samples are
//            hand-derived constants or amp*sin(k*step) from a real-valued
//            model, compared with a +/-2 LSB tolerance where CORDIC error
//            applies.
// Revision : 1.0  initial release
// ============================================================================
module tb_wave_gen;

  localparam logic [31:0] F_HALF_PI = 32'h3FC90FDB;  // pi/2
  localparam logic [31:0] F_MIDC    = 32'h3D18AEAD;  // ~0.037276 rad
  localparam logic [31:0] F_255     = 32'h437F0000;
  localparam logic [31:0] F_M255    = 32'hC37F0000;
  localparam logic [31:0] F_1000    = 32'h447A0000;
  localparam logic [31:0] F_1E6     = 32'h49742400;
  localparam logic [31:0] F_NAN     = 32'h7FC00000;
  localparam logic [31:0] F_TEN     = 32'h41200000;
  localparam logic [31:0] F_SEVEN   = 32'h40E00000;
  localparam real         MIDC_RAD  = 0.03727596;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        aud_req = 1'b0;
  logic [31:0] aud_step = 32'd0;
  logic [31:0] aud_amp = 32'd0;
  logic [15:0] aud_data;
  logic        aud_done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wave_gen dut (
    .clk      (clk),
    .reset    (reset),
    .aud_req  (aud_req),
    .aud_step (aud_step),
    .aud_amp  (aud_amp),
    .aud_data (aud_data),
    .aud_done (aud_done)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000 ns");
    $fatal(1, "watchdog expired");
  end

  function automatic int model(input real ph, input real a);
    real v;
    v = a * $sin(ph);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else          return -$rtoi(-v + 0.5);
  endfunction

  task automatic check_eq(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int exp, input int tol);
    vectors++;
    assert (((obs >= exp - tol) && (obs <= exp + tol)) === 1'b1) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    aud_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One request; checks done falls at acceptance and rises exactly 19 edges later.
  task automatic do_sample(input logic [31:0] step, input logic [31:0] amp,
                           input string tag, output int d);
    int n;
    @(negedge clk);
    aud_step = step;
    aud_amp  = amp;
    aud_req  = 1'b1;
    @(posedge clk);
    #1;
    aud_req = 1'b0;
    check_eq({tag, "_done_fall"}, int'(aud_done), 0);
    n = 0;
    while (aud_done !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq({tag, "_latency"}, n, 19);
    d = int'($signed(aud_data));
  endtask

  initial begin
    int d;
    int rises;
    int changes;
    logic prev;
    logic [15:0] hold;

    // ---- Reset values, then quarter-turn steps at amp 1000 ----
    do_reset();
    #1;
    check_eq("reset_data", int'(aud_data), 0);
    check_eq("reset_done", int'(aud_done), 0);

    do_sample(F_HALF_PI, F_1000, "q0", d); check_near("q0", d, 0, 2);
    do_sample(F_HALF_PI, F_1000, "q1", d); check_near("q1", d, 1000, 2);
    do_sample(F_HALF_PI, F_1000, "q2", d); check_near("q2", d, 0, 2);
    do_sample(F_HALF_PI, F_1000, "q3", d); check_near("q3", d, -1000, 2);
    do_sample(F_HALF_PI, F_1000, "q4", d); check_near("q4", d, 0, 2);
    do_sample(F_HALF_PI, F_1000, "q5", d); check_near("q5", d, 1000, 2);

    // ---- Middle-C sweep over a full period, including the wrap ----
    do_reset();
    for (int k = 0; k < 170; k++) begin
      do_sample(F_MIDC, F_255, "sweep", d);
      check_near($sformatf("sweep%0d", k), d, model(real'(k) * MIDC_RAD, 255.0), 2);
      repeat (k % 5) @(posedge clk);
    end

    // ---- Amplitude saturation ----
    do_reset();
    do_sample(F_HALF_PI, F_1E6, "sat0", d); check_near("sat0", d, 0, 2);
    do_sample(F_HALF_PI, F_1E6, "sat1", d); check_near("sat1", d, 32767, 2);
    do_sample(F_HALF_PI, F_1E6, "sat2", d); check_near("sat2", d, 0, 2);
    do_sample(F_HALF_PI, F_1E6, "sat3", d); check_near("sat3", d, -32767, 2);
    check_eq("sat3_floor", int'(d > -32768), 1);

    // ---- Negative amplitude negates the sweep ----
    do_reset();
    for (int k = 0; k < 46; k++) begin
      do_sample(F_MIDC, F_M255, "neg", d);
      check_near($sformatf("neg%0d", k), d, model(real'(k) * MIDC_RAD, -255.0), 2);
    end

    // ---- NaN amplitude uses full scale ----
    do_reset();
    do_sample(F_HALF_PI, F_NAN, "nan0", d); check_near("nan0", d, 0, 2);
    do_sample(F_HALF_PI, F_NAN, "nan1", d); check_near("nan1", d, 32767, 2);

    // ---- Oversized steps clamp to TWO_PI-1 (phase barely moves) ----
    do_reset();
    do_sample(F_TEN, F_1000, "ten0", d); check_near("ten0", d, 0, 2);
    do_sample(F_TEN, F_1000, "ten1", d); check_near("ten1", d, 0, 2);
    do_sample(F_TEN, F_1000, "ten2", d); check_near("ten2", d, 0, 2);
    do_reset();
    do_sample(F_SEVEN, F_1000, "sev0", d); check_near("sev0", d, 0, 2);
    do_sample(F_SEVEN, F_1000, "sev1", d); check_near("sev1", d, 0, 2);

    // ---- Held request gives exactly one sample ----
    do_reset();
    @(negedge clk);
    aud_step = F_HALF_PI;
    aud_amp  = F_1000;
    aud_req  = 1'b1;
    rises = 0;
    prev  = aud_done;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (aud_done === 1'b1 && prev === 1'b0) rises++;
      prev = aud_done;
    end
    @(negedge clk);
    aud_req = 1'b0;
    check_eq("held_rises", rises, 1);
    check_near("held_data", int'($signed(aud_data)), 0, 2);

    // ---- Extra edge during ROTATE is ignored; phase advanced only once ----
    @(negedge clk);
    aud_req = 1'b1;
    @(posedge clk);
    #1;
    aud_req = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      @(posedge clk);
      #1;
      if (c == 8)  aud_req = 1'b1;
      if (c == 10) aud_req = 1'b0;
    end
    check_eq("glitch_done_c18", int'(aud_done), 0);
    @(posedge clk);
    #1;
    check_eq("glitch_done_c19", int'(aud_done), 1);
    check_near("glitch_data", int'($signed(aud_data)), 1000, 2);
    hold    = aud_data;
    changes = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (aud_done !== 1'b1 || aud_data !== hold) changes++;
    end
    check_eq("idle_stable", changes, 0);

    // ---- Reset in the middle of ROTATE ----
    @(negedge clk);
    aud_req = 1'b1;
    @(posedge clk);
    #1;
    aud_req = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort_data", int'(aud_data), 0);
    check_eq("abort_done", int'(aud_done), 0);
    rises = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (aud_done === 1'b1) rises++;
    end
    check_eq("abort_no_sample", rises, 0);
    do_sample(F_HALF_PI, F_1000, "post0", d); check_near("post0", d, 0, 2);
    do_sample(F_HALF_PI, F_1000, "post1", d); check_near("post1", d, 1000, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
